// File: rtl/mill_modif_deco_frame.sv
// mill_modif_deco_frame: frame-aware ISO 14443-A modified Miller decoder (reader-to-card)
// Ports: clk; in_PoR async active-high reset; in_pause raw async pause (1 = carrier paused);
//   out_data/out_valid decoded bit strobe; out_sof/out_eof/out_err frame strobes; out_busy in-frame.
// Optional MILL_PARITY_CHK_EN adds out_byte/out_byte_valid/out_par_err/out_short (LSB-first, odd parity).
module mill_modif_deco_frame #(
  parameter int ETU_CLKS = 32,
  parameter int TOL = 3
) (
  input  logic       clk,
  input  logic       in_PoR,
  input  logic       in_pause,
  output logic       out_data,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eof,
  output logic       out_err,
  output logic       out_busy
`ifdef MILL_PARITY_CHK_EN
  ,
  output logic [7:0] out_byte,
  output logic       out_byte_valid,
  output logic       out_par_err,
  output logic       out_short
`endif
);
  localparam int CW = $clog2(ETU_CLKS);
  localparam logic [CW-1:0] LAST = CW'(ETU_CLKS - 1);
  localparam logic [CW-1:0] Z_HI = CW'(TOL);
  localparam logic [CW-1:0] X_LO = CW'(ETU_CLKS / 2 - TOL);
  localparam logic [CW-1:0] X_HI = CW'(ETU_CLKS / 2 + TOL);
  typedef enum logic {IDLE, RX} state_t;
  typedef enum logic [1:0] {P_SOF, P_X, P_Y, P_Z} prev_t;
  state_t state;
  prev_t prev, prev_n;
  logic [2:0] sync;
  logic [CW-1:0] cnt, off, off_now;
  logic got, dbl, sof_etu, pend_v, pend_d;
  logic pause_start, hit, is_x, is_z, is_y, bad, cls, err_c, eof_c, new_v, sof_go, emit;
  assign pause_start = sync[1] & ~sync[2];
  // A pause starting on the classification clock still belongs to the ETU being classified.
  always_comb begin
    hit = got | pause_start;
    off_now = got ? off : cnt;
    is_z = hit && off_now <= Z_HI;
    is_x = hit && off_now >= X_LO && off_now <= X_HI;
    is_y = ~hit;
    bad = dbl | (got & pause_start) | (hit & ~is_z & ~is_x);
    err_c = bad | (~sof_etu & ((is_z & prev == P_X) | (is_y & prev == P_SOF)));
    eof_c = ~err_c & ~sof_etu & is_y & (prev == P_Y | prev == P_Z);
    new_v = ~err_c & ~sof_etu & (is_x | is_z | (is_y & prev == P_X));
    prev_n = is_x ? P_X : is_z ? P_Z : P_Y;
    cls = state == RX && cnt == LAST;
    sof_go = state == IDLE && pause_start;
    emit = cls & new_v & pend_v;
  end
  // The SOF ETU is only checked for extra pauses; decoding starts with the following ETU.
  always_ff @(posedge clk or posedge in_PoR)
    if (in_PoR) begin
      sync <= '0;
      state <= IDLE;
      prev <= P_SOF;
      cnt <= '0;
      off <= '0;
      got <= 1'b0;
      dbl <= 1'b0;
      sof_etu <= 1'b0;
      pend_v <= 1'b0;
      pend_d <= 1'b0;
      out_data <= 1'b0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      out_eof <= 1'b0;
      out_err <= 1'b0;
      out_busy <= 1'b0;
    end else begin
      sync <= {sync[1:0], in_pause};
      out_sof <= sof_go;
      out_valid <= emit;
      out_data <= emit & pend_d;
      out_eof <= cls & eof_c;
      out_err <= cls & err_c;
      out_busy <= sof_go ? 1'b1 : (cls & (err_c | eof_c)) ? 1'b0 : out_busy;
      if (state == IDLE) begin
        cnt <= sof_go ? CW'(1) : '0;
        if (sof_go) begin
          state <= RX;
          got <= 1'b1;
          off <= '0;
          dbl <= 1'b0;
          sof_etu <= 1'b1;
          prev <= P_SOF;
          pend_v <= 1'b0;
        end
      end else if (cls) begin
        cnt <= '0;
        got <= 1'b0;
        dbl <= 1'b0;
        sof_etu <= 1'b0;
        if (!sof_etu) prev <= prev_n;
        if (err_c | eof_c) begin
          state <= IDLE;
          pend_v <= 1'b0;
        end else if (new_v) begin
          pend_v <= 1'b1;
          pend_d <= is_x;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (pause_start) begin
          got <= 1'b1;
          dbl <= dbl | got;
          if (!got) off <= cnt;
        end
      end
    end
`ifdef MILL_PARITY_CHK_EN
  logic [3:0] bc;
  logic [7:0] sh;
  // Bits 0..7 collect the data byte; the 9th emitted bit is the parity bit and closes the character.
  always_ff @(posedge clk or posedge in_PoR)
    if (in_PoR) begin
      bc <= '0;
      sh <= '0;
      out_byte <= '0;
      out_byte_valid <= 1'b0;
      out_par_err <= 1'b0;
      out_short <= 1'b0;
    end else begin
      out_byte_valid <= 1'b0;
      out_par_err <= 1'b0;
      out_short <= 1'b0;
      if (sof_go || (cls && (err_c || eof_c))) begin
        bc <= '0;
        sh <= '0;
        if (cls && eof_c && bc != 4'd0) begin
          out_byte_valid <= 1'b1;
          out_byte <= sh;
          out_short <= 1'b1;
        end
      end else if (emit) begin
        if (bc == 4'd8) begin
          out_byte_valid <= 1'b1;
          out_byte <= sh;
          out_par_err <= ~^{pend_d, sh};
          bc <= '0;
          sh <= '0;
        end else begin
          sh[bc[2:0]] <= pend_d;
          bc <= bc + 4'd1;
        end
      end
    end
`endif
endmodule

// File: doc/mill_modif_deco_frame.md
# mill_modif_deco_frame

Parametrised, frame-aware modified Miller decoder for the ISO 14443-A reader-to-card link, and the successor to the fixed 32-clock decoder. It sits between the envelope/pause detector and the card protocol logic. It synchronises the raw pause input, aligns its ETU timer on the start-of-frame pause, and classifies each ETU as sequence X, Y or Z. It then emits decoded bits with SOF/EOF/error strobes and, optionally, assembles parity-checked bytes.

## Interface
- ETU_CLKS, 32, clocks per ETU (even, ≥16; 32 at 3.39 MHz / 106 kbit/s)
- TOL, 3, half-width in clocks of each pause-position window (TOL < ETU_CLKS/4)
- clk  input  1  system clock
- in_PoR  input  1  reset, asynchronous, active-high
- in_pause  input  1  raw pause indication from the envelope detector, asynchronous, 1 = carrier paused
- out_data  output  1  decoded bit, valid while out_valid
- out_valid  output  1  one-clock strobe per emitted data bit
- out_sof  output  1  one-clock strobe, SOF accepted
- out_eof  output  1  one-clock strobe, EOF accepted
- out_err  output  1  one-clock strobe, coding violation; the frame is abandoned
- out_busy  output  1  high from SOF until EOF or error
- out_byte  output  8  assembled byte, LSB first (only with MILL_PARITY_CHK_EN)
- out_byte_valid  output  1  strobe for out_byte (only with MILL_PARITY_CHK_EN)
- out_par_err  output  1  qualifies out_byte_valid: odd-parity failure (only with MILL_PARITY_CHK_EN)
- out_short  output  1  qualifies out_byte_valid: partial byte at EOF (only with MILL_PARITY_CHK_EN)

## Operation
- **Input synchronisation:** in_pause passes through a 2-flop synchroniser. A pause start is a 0→1 edge on the synchronised signal.
- **States:** IDLE and RX.
- **IDLE:**
  - A pause start is the SOF (sequence Z). The ETU counter is set to offset 0 on that clock.
  - prev = SOF, pending empty, out_sof strobes, go to RX.
- **RX, per-ETU capture:**
  - The ETU counter runs 0..ETU_CLKS-1 and wraps.
  - The offset of the first pause start in the ETU is latched. Any second pause start in the same ETU is an error.
- **RX, classification** at counter = ETU_CLKS-1:
  - Z: offset 0..TOL.
  - X: offset in ETU_CLKS/2 ± TOL.
  - Y: no pause.
  - Any other offset: error.
- **Decode rules:**
  - X → bit 1.
  - Z → bit 0. Z directly after X is an error.
  - Y after X → bit 0.
  - Y after Z or Y → EOF.
  - Y directly after SOF → error.
- **One-bit pending buffer:**
  - Each decoded bit is held as pending.
  - When a bit or the EOF decision arrives, the current pending bit is handled as follows: on a new bit it is emitted (out_valid, out_data) and replaced; on EOF it is discarded, because it is the EOF's leading 0.
- **EOF:** out_eof strobes, go to IDLE.
- **Error:** out_err strobes, pending is discarded, go to IDLE. No EOF is reported.
- **Output encoding:** all strobes are registered and last exactly one clock.

## Timing
- **Reset:** on in_PoR = 1, every output is 0, the state is IDLE, the counter is 0, pending is empty, and the synchroniser is cleared. Reset is effective immediately, including mid-frame; no strobe is emitted on reset.
- **SOF latency:** in_pause rising → out_sof high 3 clocks later (2 synchroniser stages plus a register).
- **Bit latency:** the bit for ETU k is emitted one clock after classification of ETU k+1. This is a one-ETU delay by design.
- **EOF latency:** out_eof goes high one clock after the classification of the terminating Y.
- **Error latency:** out_err goes high one clock after the classification in which the violation is detected.
- **Simultaneous events:** a pause start at counter = ETU_CLKS-1 belongs to the current ETU. It is evaluated against the windows and falls outside them, so it is an error.
- **Counter width:** $clog2(ETU_CLKS). The offset comparison is unsigned. The windows do not wrap across the ETU boundary.
- **out_busy** rises with out_sof and falls with out_eof or out_err.

## Configuration
- **MILL_PARITY_CHK_EN defined:**
  - Emitted bits are shifted LSB-first into a 9-bit character (8 data bits plus an odd-parity bit).
  - On the 9th bit: out_byte_valid pulses together with out_byte. out_par_err = 1 if the nine bits contain an even number of ones.
  - At EOF with 1..8 residual bits: out_byte_valid pulses with the zero-extended residual and out_short = 1. This pulse occurs on the same clock as out_eof.
  - The bit counter clears on SOF, EOF, error and reset.
- **MILL_PARITY_CHK_EN undefined:** the byte logic and its four ports are absent. The bit-level behaviour is identical.

## Test plan
All scenarios use ETU_CLKS = 32 and TOL = 3.
- SOF, X, Y, Z, Z, Y (pauses at offsets 0/16/–/0/0/–) → out_sof; bits 1, 0, 0 on out_valid; out_eof after the last ETU; out_err never asserted.
- Window edges:
  - X pause at offset 19 → decodes to 1.
  - Offset 20 → out_err one clock after classification, state returns to IDLE.
  - Z at offset 3 is accepted; offset 4 → out_err.
- SOF then Y → out_err; Z after X → out_err; two pauses in one ETU → out_err; no out_eof in any of these cases.
- Assert in_PoR in the middle of the 3rd ETU → all outputs 0 at once, no strobes. A subsequent SOF decodes normally.
- (Parity enabled) Send 0x93 with parity 1 → out_byte = 0x93, out_par_err = 0. With parity 0 → out_par_err = 1.
- (Parity enabled) REQA, 7 bits 0x26 → EOF clock shows out_byte = 0x26 and out_short = 1.
